// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: decoder bit
// positions, md_op encodings and controller state encoding.
package muldiv_pkg;

    localparam int IDX_MULT  = 47;
    localparam int IDX_MULTU = 48;
    localparam int IDX_DIV   = 53;
    localparam int IDX_DIVU  = 32;
    localparam int IDX_MFHI  = 42;
    localparam int IDX_MFLO  = 43;
    localparam int IDX_MTHI  = 45;
    localparam int IDX_MTLO  = 46;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    // Several muldiv bits at once is illegal; pick a fixed winner so the op is defined.
    function automatic logic [1:0] op_select(input logic mult, input logic multu, input logic div);
        logic [1:0] op;
        if (mult) begin
            op = OP_MULT;
        end else if (multu) begin
            op = OP_MULTU;
        end else if (div) begin
            op = OP_DIV;
        end else begin
            op = OP_DIVU;
        end
        return op;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regfile.sv
// HI/LO architectural registers with a move-to write port and a
// mul/div result write port.
module hilo_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_mt_data,
    input  logic        i_res_we,
    input  logic [31:0] i_res_hi,
    input  logic [31:0] i_res_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Result and move-to writes never coincide; the result would win if they did.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'h0000_0000;
            r_lo <= 32'h0000_0000;
        end else if (i_res_we) begin
            r_hi <= i_res_hi;
            r_lo <= i_res_lo;
        end else begin
            if (i_mthi) begin
                r_hi <= i_mt_data;
            end
            if (i_mtlo) begin
                r_lo <= i_mt_data;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: issues ops to an external iterative unit,
// stalls the core while busy and services MFHI/MFLO/MTHI/MTLO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int CODE_W  = 54,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [CODE_W-1:0] code,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       hilo_rdata,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic [31:0]       md_a,
    output logic [31:0]       md_b,
    output logic              md_abort,
    input  logic              md_done,
    input  logic [31:0]       md_hi,
    input  logic [31:0]       md_lo,
    output logic              timeout_err,
    output logic [31:0]       hi_q,
    output logic [31:0]       lo_q
);

    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_md_start;
    logic             r_md_abort;
    logic             r_timeout_err;
    logic [1:0]       r_md_op;
    logic [31:0]      r_md_a;
    logic [31:0]      r_md_b;

    logic        w_mult, w_multu, w_div, w_divu;
    logic        w_mthi, w_mtlo, w_mfhi, w_mflo;
    logic        w_is_muldiv, w_is_mt, w_is_mf;
    logic [1:0]  w_op;
    logic        w_divzero, w_accept, w_mt_ok;
    logic        w_stall, w_res_we, w_abort_set, w_tmo_set;
    logic [31:0] w_hi, w_lo;
    logic        w_code_unused;

    assign w_mult  = instr_valid & code[IDX_MULT];
    assign w_multu = instr_valid & code[IDX_MULTU];
    assign w_div   = instr_valid & code[IDX_DIV];
    assign w_divu  = instr_valid & code[IDX_DIVU];
    assign w_mthi  = instr_valid & code[IDX_MTHI];
    assign w_mtlo  = instr_valid & code[IDX_MTLO];
    assign w_mfhi  = instr_valid & code[IDX_MFHI];
    assign w_mflo  = instr_valid & code[IDX_MFLO];

    // Class priority on illegal multi-hot codes: muldiv, then move-to, then move-from.
    assign w_is_muldiv = w_mult | w_multu | w_div | w_divu;
    assign w_is_mt     = ~w_is_muldiv & (w_mthi | w_mtlo);
    assign w_is_mf     = ~w_is_muldiv & ~w_is_mt & (w_mfhi | w_mflo);

    assign w_op      = op_select(w_mult, w_multu, w_div);
    assign w_divzero = w_op[1] & (rt_val == 32'h0000_0000);
    assign w_accept  = (r_state == ST_IDLE) & w_is_muldiv & ~w_divzero & ~flush;
    assign w_mt_ok   = (r_state == ST_IDLE) & w_is_mt & ~flush;

    // Remaining decoder bits belong to other execution units.
    assign w_code_unused = ^code;

    // Next-state, stall and one-shot event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_res_we    = 1'b0;
        w_abort_set = 1'b0;
        w_tmo_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                    w_stall     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                    w_abort_set = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                    w_abort_set = 1'b1;
                end else if (md_done) begin
                    w_state_nxt = ST_IDLE;
                    w_res_we    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_abort_set = 1'b1;
                    w_tmo_set   = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_md_start    <= 1'b0;
            r_md_abort    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_md_op       <= 2'b00;
            r_md_a        <= 32'h0000_0000;
            r_md_b        <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_md_start <= w_accept;
            r_md_abort <= w_abort_set;
            r_cnt      <= (r_state == ST_WAIT) ? (r_cnt + 8'd1) : 8'd0;
            if (w_accept) begin
                r_md_op <= w_op;
                r_md_a  <= rs_val;
                r_md_b  <= rt_val;
            end
            if (w_tmo_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    hilo_regfile u_hilo (
        .clk       (clk),
        .rst       (rst),
        .i_mthi    (w_mt_ok & w_mthi),
        .i_mtlo    (w_mt_ok & w_mtlo),
        .i_mt_data (rs_val),
        .i_res_we  (w_res_we),
        .i_res_hi  (md_hi),
        .i_res_lo  (md_lo),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    // Move-from read port; HI wins if both move-from bits are set.
    always_comb begin
        if (w_is_mf & w_mfhi) begin
            hilo_rdata = w_hi;
        end else if (w_is_mf & w_mflo) begin
            hilo_rdata = w_lo;
        end else begin
            hilo_rdata = 32'h0000_0000;
        end
    end

    assign stall       = w_stall;
    assign md_start    = r_md_start;
    assign md_abort    = r_md_abort;
    assign md_op       = r_md_op;
    assign md_a        = r_md_a;
    assign md_b        = r_md_b;
    assign timeout_err = r_timeout_err;
    assign hi_q        = w_hi;
    assign lo_q        = w_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a cycle-level expectation model is checked
// against the DUT every cycle, plus literal checks pinning key results.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

    localparam int CODE_W = 54;
    localparam int TMO    = 64;
    localparam int B_MULT = 47, B_MULTU = 48, B_DIV = 53, B_DIVU = 32;
    localparam int B_MFHI = 42, B_MFLO = 43, B_MTHI = 45, B_MTLO = 46;

    logic              clk = 1'b0;
    logic              rst, instr_valid, flush, md_done;
    logic [CODE_W-1:0] code;
    logic [31:0]       rs_val, rt_val, md_hi, md_lo;
    logic              stall, md_start, md_abort, timeout_err;
    logic [1:0]        md_op;
    logic [31:0]       hilo_rdata, md_a, md_b, hi_q, lo_q;

    muldiv_ctrl #(.CODE_W(CODE_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .code(code),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
        .hilo_rdata(hilo_rdata), .md_start(md_start), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .md_abort(md_abort), .md_done(md_done),
        .md_hi(md_hi), .md_lo(md_lo), .timeout_err(timeout_err),
        .hi_q(hi_q), .lo_q(lo_q)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // expectation model state
    logic [31:0] exp_hi = 32'h0, exp_lo = 32'h0, exp_a = 32'h0, exp_b = 32'h0;
    logic [1:0]  exp_op = 2'b00;
    logic        exp_err = 1'b0, exp_stall = 1'b0, exp_start = 1'b0, exp_abort = 1'b0;
    logic        pend_start = 1'b0, pend_abort = 1'b0, pend_err = 1'b0, pend_rst = 1'b0;
    logic        pend_hi_we = 1'b0, pend_lo_we = 1'b0;
    logic [31:0] pend_hi = 32'h0, pend_lo = 32'h0;

    int          obs_stall = 0, obs_start = 0, obs_abort = 0;
    logic        snap_stall, snap_err, snap_start;
    logic [31:0] snap_rdata, snap_hi, snap_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] md_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        logic [63:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            2'b00:   r = sa * sb;
            2'b01:   r = {32'h0, a} * {32'h0, b};
            2'b10:   r = {32'(qa % qb), 32'(qa / qb)};
            default: r = {a % b, a / b};
        endcase
        return r;
    endfunction

    function automatic int op_bit(input logic [1:0] op);
        case (op)
            2'b00:   return B_MULT;
            2'b01:   return B_MULTU;
            2'b10:   return B_DIV;
            default: return B_DIVU;
        endcase
    endfunction

    function automatic logic [31:0] model_rdata();
        if (instr_valid !== 1'b1) return 32'h0;
        if (code[B_MULT] | code[B_MULTU] | code[B_DIV] | code[B_DIVU] |
            code[B_MTHI] | code[B_MTLO]) return 32'h0;
        if (code[B_MFHI]) return exp_hi;
        if (code[B_MFLO]) return exp_lo;
        return 32'h0;
    endfunction

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                check("stall", 32'(stall), 32'(exp_stall));
                check("md_start", 32'(md_start), 32'(exp_start));
                check("md_abort", 32'(md_abort), 32'(exp_abort));
                check("timeout_err", 32'(timeout_err), 32'(exp_err));
                check("hi_q", hi_q, exp_hi);
                check("lo_q", lo_q, exp_lo);
                check("hilo_rdata", hilo_rdata, model_rdata());
                if (exp_start) begin
                    check("md_op", 32'(md_op), 32'(exp_op));
                    check("md_a", md_a, exp_a);
                    check("md_b", md_b, exp_b);
                end
            end
        end
    end

    // one clock: observe this cycle, apply the model's edge updates, clear pulses
    task automatic step();
        @(negedge clk);
        obs_stall += int'(stall);
        obs_start += int'(md_start);
        obs_abort += int'(md_abort);
        snap_stall = stall; snap_err = timeout_err; snap_start = md_start;
        snap_rdata = hilo_rdata; snap_hi = hi_q; snap_lo = lo_q;
        @(posedge clk);
        if (pend_rst) begin
            exp_hi = 32'h0; exp_lo = 32'h0; exp_err = 1'b0;
        end else begin
            if (pend_hi_we) exp_hi = pend_hi;
            if (pend_lo_we) exp_lo = pend_lo;
            if (pend_err)   exp_err = 1'b1;
        end
        exp_start = pend_start & ~pend_rst;
        exp_abort = pend_abort & ~pend_rst;
        {pend_start, pend_abort, pend_err, pend_rst, pend_hi_we, pend_lo_we} = 6'b0;
        exp_stall = 1'b0;
        #1;
        md_done = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        code = '0;
        repeat (n) step();
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] data,
                      input logic [CODE_W-1:0] extra, input bit fl);
        instr_valid = 1'b1;
        code = extra;
        code[to_hi ? B_MTHI : B_MTLO] = 1'b1;
        rs_val = data;
        flush = fl;
        if (!fl) begin
            if (to_hi) begin pend_hi_we = 1'b1; pend_hi = data; end
            else       begin pend_lo_we = 1'b1; pend_lo = data; end
        end
        step();
        instr_valid = 1'b0;
        code = '0;
    endtask

    task automatic mf(input bit from_hi);
        instr_valid = 1'b1;
        code = '0;
        code[from_hi ? B_MFHI : B_MFLO] = 1'b1;
        step();
        instr_valid = 1'b0;
        code = '0;
    endtask

    // lat: WAIT cycles before md_done (<0 never); flush_at: 0 ISSUE, w>=1 that WAIT cycle, <0 none
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at, input bit spur);
        logic [63:0] res;
        int          w;
        bit          fin;
        bit          done_now;
        obs_stall = 0; obs_start = 0; obs_abort = 0;
        instr_valid = 1'b1;
        code = '0;
        code[op_bit(op)] = 1'b1;
        rs_val = a;
        rt_val = b;
        if (op[1] && b == 32'h0) begin
            step();
            instr_valid = 1'b0;
            code = '0;
            return;
        end
        res = md_model(op, a, b);
        exp_stall = 1'b1; pend_start = 1'b1; exp_op = op; exp_a = a; exp_b = b;
        step();
        exp_stall = 1'b1;
        fin = 1'b0;
        if (spur) begin md_done = 1'b1; md_hi = 32'hDEAD_0000; md_lo = 32'h0000_BEEF; end
        if (flush_at == 0) begin flush = 1'b1; pend_abort = 1'b1; fin = 1'b1; end
        step();
        w = 1;
        while (!fin && w <= TMO + 2) begin
            done_now = (lat >= 0) && (w == lat + 1);
            if (done_now) begin md_done = 1'b1; md_hi = res[63:32]; md_lo = res[31:0]; end
            if (w == flush_at) begin
                flush = 1'b1; pend_abort = 1'b1; fin = 1'b1;
            end else if (done_now) begin
                pend_hi_we = 1'b1; pend_hi = res[63:32];
                pend_lo_we = 1'b1; pend_lo = res[31:0];
                fin = 1'b1;
            end else if (w == TMO) begin
                pend_abort = 1'b1; pend_err = 1'b1; fin = 1'b1;
            end else begin
                exp_stall = 1'b1;
            end
            step();
            w++;
        end
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL run_md_bound: got %0d wait cycles expected at most %0d", w, TMO);
        end
        instr_valid = 1'b0;
        code = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CODE_W-1:0] extra;
        rst = 1'b1; instr_valid = 1'b0; flush = 1'b0; md_done = 1'b0;
        code = '0; rs_val = 32'h0; rt_val = 32'h0; md_hi = 32'h0; md_lo = 32'h0;
        pend_rst = 1'b1; step();
        pend_rst = 1'b1; step();
        rst = 1'b0;
        idle(2);
        check("reset_hi", snap_hi, 32'h0);
        check("reset_lo", snap_lo, 32'h0);
        check("reset_err", 32'(snap_err), 32'h0);
        check("reset_stall", 32'(snap_stall), 32'h0);

        // MULT -3 * 5, unit answers after 3 WAIT cycles
        run_md(2'b00, 32'hFFFF_FFFD, 32'd5, 3, -1, 1'b0);
        check("mult_stall_cycles", 32'(obs_stall), 32'd5);
        check("mult_start_pulses", 32'(obs_start), 32'd1);
        check("mult_model_hi", exp_hi, 32'hFFFF_FFFF);
        check("mult_model_lo", exp_lo, 32'hFFFF_FFF1);
        mf(1'b1);
        check("mfhi_after_mult", snap_rdata, 32'hFFFF_FFFF);
        mf(1'b0);
        check("mflo_after_mult", snap_rdata, 32'hFFFF_FFF1);

        // DIVU by zero retires at once
        run_md(2'b11, 32'd7, 32'd0, 3, -1, 1'b0);
        check("divz_stall", 32'(snap_stall), 32'h0);
        idle(2);
        check("divz_no_start", 32'(obs_start), 32'h0);
        check("divz_hi", snap_hi, 32'hFFFF_FFFF);

        // MTHI then MFHI next cycle
        mt(1'b1, 32'h0000_1234, '0, 1'b0);
        mf(1'b1);
        check("mthi_mfhi", snap_rdata, 32'h0000_1234);
        check("mthi_lo_kept", snap_lo, 32'hFFFF_FFF1);

        // flushed MTLO is dropped; MTLO with MFHI set writes LO and reads nothing
        mt(1'b0, 32'h5555_5555, '0, 1'b1);
        extra = '0;
        extra[B_MFHI] = 1'b1;
        mt(1'b0, 32'hA5A5_0001, extra, 1'b0);
        check("mt_over_mf_rdata", snap_rdata, 32'h0);
        mf(1'b0);
        check("mtlo_mflo", snap_rdata, 32'hA5A5_0001);

        // DIVU with immediate answer
        run_md(2'b11, 32'hFFFF_FFF0, 32'd3, 0, -1, 1'b0);
        check("divu_model_lo", exp_lo, 32'h5555_5550);
        check("divu_model_hi", exp_hi, 32'h0);
        idle(1);

        // DIV flushed in 2nd WAIT cycle while done arrives, then a stray done
        run_md(2'b10, 32'd100, 32'hFFFF_FFF9, 1, 2, 1'b0);
        check("flush_stall_drop", 32'(snap_stall), 32'h0);
        idle(1);
        md_done = 1'b1; md_hi = 32'h1111_1111; md_lo = 32'h2222_2222;
        step();
        idle(2);
        check("flush_abort_pulses", 32'(obs_abort), 32'd1);
        check("flush_hi_kept", snap_hi, 32'h0);
        check("flush_lo_kept", snap_lo, 32'h5555_5550);

        // signed DIV with negative dividend
        run_md(2'b10, 32'hFFFF_FF9C, 32'd7, 2, -1, 1'b0);
        check("div_model_lo", exp_lo, 32'hFFFF_FFF2);
        check("div_model_hi", exp_hi, 32'hFFFF_FFFE);
        idle(1);

        // flush during ISSUE
        run_md(2'b01, 32'd9, 32'd9, 4, 0, 1'b0);
        idle(2);
        check("issue_flush_abort", 32'(obs_abort), 32'd1);

        // MULTU with a unit that never answers
        run_md(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
        check("tmo_stall_cycles", 32'(obs_stall), 32'd65);
        idle(1);
        check("tmo_abort", 32'(obs_abort), 32'd1);
        check("tmo_err", 32'(snap_err), 32'd1);

        // MULT still works afterwards; a done during ISSUE is ignored
        run_md(2'b00, 32'h7FFF_FFFF, 32'd2, 0, -1, 1'b1);
        check("mult2_model_lo", exp_lo, 32'hFFFF_FFFE);
        check("mult2_model_hi", exp_hi, 32'h0);
        idle(1);
        check("tmo_err_sticky", 32'(snap_err), 32'd1);

        // reset while in WAIT
        instr_valid = 1'b1; code = '0; code[B_MULT] = 1'b1; rs_val = 32'd3; rt_val = 32'd4;
        exp_stall = 1'b1; pend_start = 1'b1; exp_op = 2'b00; exp_a = 32'd3; exp_b = 32'd4;
        step();
        exp_stall = 1'b1; step();
        exp_stall = 1'b1; step();
        rst = 1'b1; pend_rst = 1'b1; step();
        rst = 1'b0; instr_valid = 1'b0; code = '0;
        step();
        check("rst_stall", 32'(snap_stall), 32'h0);
        check("rst_start", 32'(snap_start), 32'h0);
        check("rst_hi", snap_hi, 32'h0);
        check("rst_lo", snap_lo, 32'h0);
        check("rst_err", 32'(snap_err), 32'h0);

        run_md(2'b00, 32'd6, 32'd7, 1, -1, 1'b0);
        idle(1);
        check("post_rst_mult_lo", snap_lo, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the HI/LO multiply/divide resource for the 54-instruction CPU.
- Consumes the one-hot decoder vector plus register operands, and owns the HI and LO architectural registers.
- Issues MULT/MULTU/DIV/DIVU to an external iterative mul/div unit using a start/done handshake.
- Stalls the core while an operation is in flight and services MFHI/MFLO/MTHI/MTLO.

Parameters:
- CODE_W, 54, width of the decoded one-hot instruction vector.
- TIMEOUT, 64, maximum cycles spent in WAIT before abort; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  qualifies code; code is ignored when low (the decoder emits X on unknown opcodes).
- code  in  CODE_W  one-hot decoded instruction.
- rs_val  in  32  rs operand.
- rt_val  in  32  rt operand.
- flush  in  1  exception/ERET/SYSCALL flush; aborts any in-flight operation.
- stall  out  1  core must hold PC and instruction while high.
- hilo_rdata  out  32  HI when MFHI, LO when MFLO, otherwise 0; combinational.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_op  out  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; registered.
- md_a  out  32  registered rs operand.
- md_b  out  32  registered rt operand.
- md_abort  out  1  one-cycle pulse cancelling the unit.
- md_done  in  1  unit result valid; single-cycle pulse.
- md_hi  in  32  unit HI result.
- md_lo  in  32  unit LO result.
- timeout_err  out  1  sticky error flag; cleared only by rst.
- hi_q  out  32  current HI register value.
- lo_q  out  32  current LO register value.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE; hi_q=lo_q=0; md_start=md_abort=0; md_op=0; md_a=md_b=0; timeout_err=0; wait counter=0. rst overrides all other inputs, including mid-operation.
- Instruction classes, by code bit:
  - muldiv: bit 47 MULT, 48 MULTU, 53 DIV, 32 DIVU.
  - move-from: bit 42 MFHI, 43 MFLO.
  - move-to: bit 45 MTHI, 46 MTLO.
  - All other bits are ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - instr_valid & muldiv & !flush, and not a divide with rt_val==0:
    - Latch md_a=rs_val, md_b=rt_val, md_op; go to ISSUE.
  - DIV/DIVU with rt_val==0: no issue; HI/LO unchanged; stall=0; instruction retires in 1 cycle.
  - MTHI/MTLO (valid, !flush): hi_q or lo_q <= rs_val at the edge; no stall.
- ISSUE:
  - md_start=1 for exactly this cycle; go to WAIT; counter cleared.
  - flush in ISSUE: md_abort pulses next cycle; return to IDLE.
- WAIT:
  - md_done: hi_q<=md_hi, lo_q<=md_lo; go to IDLE.
  - flush (priority over md_done): return to IDLE; HI/LO unchanged; md_abort=1 for one cycle.
  - Counter reaches TIMEOUT-1 with no done: timeout_err<=1, md_abort pulse, go to IDLE; HI/LO unchanged.
- Stall equation: stall = (IDLE & instr_valid & muldiv & !divzero & !flush) | ISSUE | (WAIT & !md_done & !flush & !timeout_hit).
  - The core advances on the same edge HI/LO are written.
  - Latency: total stall cycles = 2 + N, where N is the number of cycles from md_start to md_done.
- md_done seen outside WAIT is ignored.
- Reads: hilo_rdata reflects registered HI/LO; an MTHI in cycle t is visible to an MFHI in cycle t+1.
- Multiple class bits set simultaneously (illegal): priority is muldiv > move-to > move-from.

Decomposition:
- Shared package muldiv_pkg holds:
  - decoder bit indices (IDX_MULT=47, IDX_MULTU=48, IDX_DIV=53, IDX_DIVU=32, IDX_MFHI=42, IDX_MFLO=43, IDX_MTHI=45, IDX_MTLO=46);
  - md_op encodings;
  - FSM state encoding.
- One natural sub-module: hilo_regfile (HI/LO registers with MT write and mul/div result write ports).

Test Plan:
- MULT, rs=0xFFFFFFFD, rt=5; model answers md_hi=0xFFFFFFFF, md_lo=0xFFFFFFF1 three cycles after md_start -> one md_start pulse, md_op=00, stall high for 5 cycles; next-cycle MFHI hilo_rdata=0xFFFFFFFF, MFLO=0xFFFFFFF1.
- DIVU, rs=7, rt=0 -> md_start never asserted, stall=0, hi_q/lo_q unchanged.
- MTHI rs=0x00001234, then MFHI the next cycle -> hilo_rdata=0x00001234; lo_q unchanged.
- DIV issued, flush asserted in the 2nd WAIT cycle, md_done arriving in the same cycle -> md_abort one pulse, HI/LO unchanged, stall drops in the flush cycle, later md_done ignored.
- MULTU with a model that never returns done -> exactly 64 WAIT cycles, then timeout_err=1 (sticky), md_abort pulse, stall=0; a subsequent MULT still works normally.
- rst asserted while in WAIT -> next cycle stall=0, md_start=0, hi_q=lo_q=0, timeout_err=0, state IDLE.
